// File: rtl/clock_divider_multi_pkg.sv
// Shared types and constants for the multi-channel clock divider.
// Optional phase-sync input is compiled in with CLKDIV_SYNC_EN.
package clock_divider_multi_pkg;

  typedef enum logic {
    MODE_TOGGLE = 1'b0,
    MODE_TICK   = 1'b1
  } mode_e;

  localparam int CNT_W_DEF       = 28;
  localparam int DEFAULT_DIV_DEF = 1000000;

endpackage

`define CLKDIV_SLICE(vec, idx, w) vec[(idx)*(w) +: (w)]

// File: rtl/clock_divider_multi_channel.sv
// One divider channel: period counter, shadow divisor/mode, registered
// square-wave and tick outputs.
module clkdiv_channel
  import clock_divider_multi_pkg::*;
#(
  parameter int CNT_W       = CNT_W_DEF,
  parameter int DEFAULT_DIV = DEFAULT_DIV_DEF
) (
  input  logic             i_clock,
  input  logic             reset,
  input  logic             i_en,
  input  logic             i_sync,
  input  logic             i_mode,
  input  logic [CNT_W-1:0] i_div,
  output logic             o_clock,
  output logic             o_tick
);

  localparam logic [CNT_W-1:0] DIV_RST = CNT_W'(DEFAULT_DIV);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] div_q, div_d;
  mode_e            mode_q, mode_d;
  logic             clk_q, clk_d;
  logic             tick_q, tick_d;
  logic             tc;
  mode_e            mode_in;

  assign tc      = (cnt_q == div_q);
  assign mode_in = mode_e'(i_mode);

  always_comb begin
    cnt_d  = cnt_q;
    div_d  = div_q;
    mode_d = mode_q;
    clk_d  = clk_q;
    tick_d = 1'b0;
    if (!i_en || i_sync) begin
      cnt_d  = '0;
      clk_d  = 1'b0;
      div_d  = i_div;
      mode_d = mode_in;
    end else if (tc) begin
      // New mode decides the edge so a switch to tick mode lands low.
      cnt_d  = '0;
      tick_d = 1'b1;
      clk_d  = (mode_in == MODE_TICK) ? 1'b0 : ~clk_q;
      div_d  = i_div;
      mode_d = mode_in;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge i_clock or posedge reset) begin
    if (reset) begin
      cnt_q  <= '0;
      div_q  <= DIV_RST;
      mode_q <= MODE_TOGGLE;
      clk_q  <= 1'b0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      div_q  <= div_d;
      mode_q <= mode_d;
      clk_q  <= clk_d;
      tick_q <= tick_d;
    end
  end

  assign o_clock = clk_q;
  assign o_tick  = tick_q;

endmodule

// File: rtl/clock_divider_multi.sv
// NUM_CH independent programmable dividers.
// Define CLKDIV_SYNC_EN to add i_sync, which phase-aligns all channels.
module clock_divider_multi
  import clock_divider_multi_pkg::*;
#(
  parameter int NUM_CH      = 4,
  parameter int CNT_W       = CNT_W_DEF,
  parameter int DEFAULT_DIV = DEFAULT_DIV_DEF
) (
  input  logic                    i_clock,
  input  logic                    reset,
  input  logic [NUM_CH-1:0]       i_en,
  input  logic [NUM_CH-1:0]       i_mode,
  input  logic [NUM_CH*CNT_W-1:0] i_div,
`ifdef CLKDIV_SYNC_EN
  input  logic                    i_sync,
`endif
  output logic [NUM_CH-1:0]       o_clock,
  output logic [NUM_CH-1:0]       o_tick
);

  logic sync;

`ifdef CLKDIV_SYNC_EN
  assign sync = i_sync;
`else
  assign sync = 1'b0;
`endif

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    clkdiv_channel #(
      .CNT_W       (CNT_W),
      .DEFAULT_DIV (DEFAULT_DIV)
    ) u_ch (
      .i_clock (i_clock),
      .reset   (reset),
      .i_en    (i_en[c]),
      .i_sync  (sync),
      .i_mode  (i_mode[c]),
      .i_div   (`CLKDIV_SLICE(i_div, c, CNT_W)),
      .o_clock (o_clock[c]),
      .o_tick  (o_tick[c])
    );
  end

endmodule
